// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: widths, opcode tags, flag/entry structs, FSM states.
// ALU_RESULT_PARITY_EN adds a parity bit to the stored flags.
package alu_pkg;

    localparam int ALU_W = 8;
    localparam int OP_W  = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_PASS = 3'd7
    } alu_op_e;

    typedef struct packed {
`ifdef ALU_RESULT_PARITY_EN
        logic par;
`endif
        logic zero;
        logic neg;
    } alu_flags_t;

    typedef struct packed {
        logic [ALU_W-1:0] y;
        logic [OP_W-1:0]  op;
        alu_flags_t       flags;
    } alu_entry_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status flags for one ALU result.
// ALU_RESULT_PARITY_EN adds par = ^y (1 when the result has an odd number of ones).
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] y,
    output alu_flags_t       flags
);

    always_comb begin
        flags      = '0;
        flags.zero = (y == '0);
        flags.neg  = y[WIDTH-1];
`ifdef ALU_RESULT_PARITY_EN
        flags.par  = ^y;
`endif
    end

endmodule

// File: rtl/alu_result_stage.sv
// Two-entry registered buffer (head + skid) between the ALU result mux and writeback.
// ALU_RESULT_PARITY_EN adds the out_par port and per-entry parity storage.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::ALU_W,
    parameter int OP_W  = alu_pkg::OP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_y,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [OP_W-1:0]  out_op,
    output logic             out_zero,
    output logic             out_neg,
`ifdef ALU_RESULT_PARITY_EN
    output logic             out_par,
`endif
    output logic [1:0]       occ
);

    stage_state_e state_q, state_d;
    alu_entry_t   head_q, head_d;
    alu_entry_t   skid_q, skid_d;
    alu_entry_t   new_entry;
    alu_flags_t   new_flags;
    logic         push;
    logic         pop;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .y     (in_y),
        .flags (new_flags)
    );

    // Readiness depends only on state, so out_ready never combinationally reaches in_ready.
    assign in_ready  = (state_q != ST_FULL) && !rst;
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        new_entry       = '0;
        new_entry.y     = in_y;
        new_entry.op    = in_op;
        new_entry.flags = new_flags;
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_d  = new_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = new_entry;
                end else if (push) begin
                    skid_d  = new_entry;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign out_y    = head_q.y;
    assign out_op   = head_q.op;
    assign out_zero = head_q.flags.zero;
    assign out_neg  = head_q.flags.neg;
`ifdef ALU_RESULT_PARITY_EN
    assign out_par  = head_q.flags.par;
`endif
    assign occ      = state_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage; parity checks run only with ALU_RESULT_PARITY_EN.
module tb_alu_result_stage;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_y;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic [2:0] out_op;
    logic       out_zero;
    logic       out_neg;
`ifdef ALU_RESULT_PARITY_EN
    logic       out_par;
`endif
    logic [1:0] occ;

    int checks = 0;
    int errors = 0;

    alu_result_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_op    (out_op),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
`ifdef ALU_RESULT_PARITY_EN
        .out_par   (out_par),
`endif
        .occ       (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_y      = 8'h00;
        in_op     = 3'd0;
        out_ready = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_occ",       32'(occ),       32'd0);
        checkOutput("rst_out_y",     32'(out_y),     32'h00);
        checkOutput("rst_out_op",    32'(out_op),    32'd0);
        checkOutput("rst_flags",     32'({out_zero, out_neg}), 32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rel_in_ready",  32'(in_ready),  32'd1);

        // Single push into EMPTY, popped on the following cycle.
        in_valid  = 1'b1;
        in_y      = 8'h00;
        in_op     = OP_NOR;
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("t1_out_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_out_y",     32'(out_y),     32'h00);
        checkOutput("t1_out_op",    32'(out_op),    32'(OP_NOR));
        checkOutput("t1_zero",      32'(out_zero),  32'd1);
        checkOutput("t1_neg",       32'(out_neg),   32'd0);
        in_valid = 1'b0;
        applyStimulus();
        checkOutput("t1_occ_after_pop", 32'(occ),       32'd0);
        checkOutput("t1_valid_after",   32'(out_valid), 32'd0);

        // Fill both entries with writeback stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_y      = 8'h80;
        in_op     = OP_AND;
        applyStimulus();
        in_y  = 8'h0F;
        in_op = OP_OR;
        applyStimulus();
        checkOutput("t2_occ",      32'(occ),      32'd2);
        checkOutput("t2_in_ready", 32'(in_ready), 32'd0);
        checkOutput("t2_out_y",    32'(out_y),    32'h80);
        checkOutput("t2_neg",      32'(out_neg),  32'd1);
        checkOutput("t2_zero",     32'(out_zero), 32'd0);
        in_y  = 8'hAA;
        in_op = OP_XOR;
        applyStimulus();
        checkOutput("t2_hold_occ",   32'(occ),    32'd2);
        checkOutput("t2_hold_out_y", 32'(out_y),  32'h80);
        checkOutput("t2_hold_op",    32'(out_op), 32'(OP_AND));

        // Drain in order while the third entry stays offered.
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("t3_pop1_y",     32'(out_y),    32'h0F);
        checkOutput("t3_pop1_op",    32'(out_op),   32'(OP_OR));
        checkOutput("t3_pop1_occ",   32'(occ),      32'd1);
        checkOutput("t3_ready_back", 32'(in_ready), 32'd1);
        applyStimulus();
        checkOutput("t3_third_y",    32'(out_y),    32'hAA);
        checkOutput("t3_third_op",   32'(out_op),   32'(OP_XOR));
        checkOutput("t3_third_occ",  32'(occ),      32'd1);
        in_valid = 1'b0;
        applyStimulus();
        checkOutput("t3_drain_occ",  32'(occ),      32'd0);

        // Simultaneous push and pop in ONE.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_y      = 8'h33;
        in_op     = OP_PASS;
        applyStimulus();
        checkOutput("t4_pre_y", 32'(out_y), 32'h33);
        in_y      = 8'h55;
        in_op     = OP_XNOR;
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("t4_occ",   32'(occ),    32'd1);
        checkOutput("t4_out_y", 32'(out_y),  32'h55);
        checkOutput("t4_op",    32'(out_op), 32'(OP_XNOR));

        // Reset from FULL discards both entries.
        out_ready = 1'b0;
        in_y      = 8'hF0;
        in_op     = OP_NAND;
        applyStimulus();
        checkOutput("t5_full_occ", 32'(occ), 32'd2);
        rst      = 1'b1;
        in_valid = 1'b0;
        applyStimulus();
        checkOutput("t5_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_occ",       32'(occ),       32'd0);
        checkOutput("t5_out_y",     32'(out_y),     32'h00);
        checkOutput("t5_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        checkOutput("t5_rel_ready", 32'(in_ready),  32'd1);
        in_valid  = 1'b1;
        in_y      = 8'h01;
        in_op     = OP_NOT;
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("t5_new_y",     32'(out_y),     32'h01);
        checkOutput("t5_new_flags", 32'({out_zero, out_neg}), 32'd0);
        in_valid = 1'b0;
        applyStimulus();
        checkOutput("t5_no_stale_occ",   32'(occ),       32'd0);
        checkOutput("t5_no_stale_valid", 32'(out_valid), 32'd0);

`ifdef ALU_RESULT_PARITY_EN
        in_valid  = 1'b1;
        in_y      = 8'h07;
        in_op     = OP_PASS;
        out_ready = 1'b0;
        applyStimulus();
        checkOutput("t6_par_07", 32'(out_par), 32'd1);
        in_y      = 8'h03;
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("t6_par_03", 32'(out_par), 32'd0);
        checkOutput("t6_y_03",   32'(out_y),   32'h03);
        in_valid = 1'b0;
        applyStimulus();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
